// File: rtl/y_expr_checker.sv
// y_expr_checker
// Response monitor for the 4-input Y-expression lab circuit. Each accepted
// sample {vec_in, y_in} is compared against a golden 16-entry truth table.
// The monitor keeps saturating vector/error counts and input-space coverage,
// latches the first failing vector and produces a final pass/fail verdict.
//
// Ports:
//   clk_i              rising-edge clock
//   rst_n_i            synchronous active-low reset
//   start_i            pulse: clear statistics, begin (or restart) a session
//   stop_i             pulse: end the running session early
//   vec_valid_i        vec_in_i / y_in_i hold a sample
//   vec_ready_o        samples are accepted (RUN only)
//   vec_in_i           applied inputs {a,b,c,d}
//   y_in_i             observed circuit output for vec_in_i
//   busy_o / done_o    state is RUN / DONE
//   pass_o             DONE with zero errors and full coverage
//   vec_cnt_o          accepted samples (saturating)
//   err_cnt_o          mismatching samples (saturating)
//   coverage_o         bit i set once vector i has been accepted
//   first_err_*_o      first mismatch: valid flag, vector, observed y
module y_expr_checker #(
  parameter logic [15:0] TRUTH_TABLE = 16'hF444,
  parameter int          CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             vec_valid_i,
  output logic             vec_ready_o,
  input  logic [3:0]       vec_in_i,
  input  logic             y_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [15:0]      coverage_o,
  output logic             first_err_valid_o,
  output logic [3:0]       first_err_vec_o,
  output logic             first_err_y_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [15:0]      cov_q, cov_d;
  logic             fev_q, fev_d;
  logic [3:0]       fvec_q, fvec_d;
  logic             fy_q, fy_d;
  logic             pass_q, pass_d;

  logic             accept_s;
  logic             mismatch_s;
  logic [15:0]      cov_hit_s;

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // A start in RUN discards the concurrent sample, so it gates acceptance.
  assign accept_s   = vec_valid_i & (state_q == ST_RUN) & ~start_i;
  assign mismatch_s = (y_in_i != TRUTH_TABLE[vec_in_i]);
  assign cov_hit_s  = {15'd0, 1'b1} << vec_in_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start has priority over stop and completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
        else         state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (start_i)                         state_d = ST_RUN;
        else if (stop_i || cov_d == 16'hFFFF) state_d = ST_DONE;
        else                                  state_d = ST_RUN;
      end
      ST_DONE: begin
        if (start_i) state_d = ST_RUN;
        else         state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State decode outputs.
  always_comb begin
    vec_ready_o = (state_q == ST_RUN);
    busy_o      = (state_q == ST_RUN);
    done_o      = (state_q == ST_DONE);
  end

  // Statistics next-state: clear on start, update on accept, else hold.
  always_comb begin
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    cov_d     = cov_q;
    fev_d     = fev_q;
    fvec_d    = fvec_q;
    fy_d      = fy_q;
    if (start_i) begin
      vec_cnt_d = {CNT_W{1'b0}};
      err_cnt_d = {CNT_W{1'b0}};
      cov_d     = 16'd0;
      fev_d     = 1'b0;
      fvec_d    = 4'd0;
      fy_d      = 1'b0;
    end else if (accept_s) begin
      vec_cnt_d = sat_inc(vec_cnt_q);
      cov_d     = cov_q | cov_hit_s;
      if (mismatch_s) begin
        err_cnt_d = sat_inc(err_cnt_q);
        if (!fev_q) begin
          fev_d  = 1'b1;
          fvec_d = vec_in_i;
          fy_d   = y_in_i;
        end else begin
          fev_d  = fev_q;
        end
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      vec_cnt_d = vec_cnt_q;
    end
    // Verdict follows the post-edge state so it is valid together with done.
    pass_d = (state_d == ST_DONE) && (err_cnt_d == {CNT_W{1'b0}}) &&
             (cov_d == 16'hFFFF);
  end

  // Statistics and verdict registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vec_cnt_q <= {CNT_W{1'b0}};
      err_cnt_q <= {CNT_W{1'b0}};
      cov_q     <= 16'd0;
      fev_q     <= 1'b0;
      fvec_q    <= 4'd0;
      fy_q      <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      cov_q     <= cov_d;
      fev_q     <= fev_d;
      fvec_q    <= fvec_d;
      fy_q      <= fy_d;
      pass_q    <= pass_d;
    end
  end

  assign vec_cnt_o         = vec_cnt_q;
  assign err_cnt_o         = err_cnt_q;
  assign coverage_o        = cov_q;
  assign first_err_valid_o = fev_q;
  assign first_err_vec_o   = fvec_q;
  assign first_err_y_o     = fy_q;
  assign pass_o            = pass_q;

endmodule

// File: tb/tb_y_expr_checker.sv
// Testbench for y_expr_checker: directed scenarios plus randomized sessions,
// checked against a behavioural model of the session rules.
module tb_y_expr_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        vec_valid = 1'b0;
  logic        vec_ready;
  logic [3:0]  vec_in = 4'd0;
  logic        y_in = 1'b0;
  logic        busy, done, pass;
  logic [7:0]  vec_cnt, err_cnt;
  logic [15:0] coverage;
  logic        first_err_valid;
  logic [3:0]  first_err_vec;
  logic        first_err_y;

  int checks = 0;
  int errors = 0;

  y_expr_checker #(.TRUTH_TABLE(16'hF444), .CNT_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .vec_valid_i(vec_valid), .vec_ready_o(vec_ready), .vec_in_i(vec_in),
    .y_in_i(y_in), .busy_o(busy), .done_o(done), .pass_o(pass),
    .vec_cnt_o(vec_cnt), .err_cnt_o(err_cnt), .coverage_o(coverage),
    .first_err_valid_o(first_err_valid), .first_err_vec_o(first_err_vec),
    .first_err_y_o(first_err_y)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  int m_state = M_IDLE;
  int m_vec = 0, m_err = 0;
  bit m_cov [16];
  bit m_fev = 1'b0;
  int m_fvec = 0;
  bit m_fy = 1'b0;

  function automatic bit golden(input int v);
    bit a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    return (a & b) | (c & ~d);
  endfunction

  function automatic bit all_cov();
    for (int i = 0; i < 16; i++) if (!m_cov[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] cov_word();
    logic [15:0] w = 16'd0;
    for (int i = 0; i < 16; i++) w[i] = m_cov[i];
    return w;
  endfunction

  function automatic bit m_pass();
    return (m_state == M_DONE) && (m_err == 0) && all_cov();
  endfunction

  task automatic model_clear();
    m_vec = 0; m_err = 0; m_fev = 1'b0; m_fvec = 0; m_fy = 1'b0;
    for (int i = 0; i < 16; i++) m_cov[i] = 1'b0;
  endtask

  task automatic model_step(input bit rn, input bit st, input bit sp,
                            input bit v, input int vec, input bit y);
    if (!rn) begin
      model_clear();
      m_state = M_IDLE;
    end else if (st) begin
      model_clear();
      m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (v) begin
        if (m_vec < 255) m_vec++;
        m_cov[vec] = 1'b1;
        if (y != golden(vec)) begin
          if (m_err < 255) m_err++;
          if (!m_fev) begin m_fev = 1'b1; m_fvec = vec; m_fy = y; end
        end
      end
      if (sp || all_cov()) m_state = M_DONE;
    end
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after edge.
  task automatic cycle(input bit st, input bit sp, input bit v,
                       input logic [3:0] vec, input bit y);
    start = st; stop = sp; vec_valid = v; vec_in = vec; y_in = y;
    model_step(rst_n, st, sp, v, int'(vec), y);
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; vec_valid = 1'b0;
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b1, 4'(i), golden(i));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    checks++;
    if ({vec_ready, busy, done, pass, first_err_valid} !== 5'b0 ||
        vec_cnt !== 8'd0 || err_cnt !== 8'd0 || coverage !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b pass=%b fev=%b vec=%0d err=%0d cov=%h, required all zero",
               vec_ready, busy, done, pass, first_err_valid, vec_cnt, err_cnt, coverage);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 4'(i), 1'b1);
    checks++;
    if (vec_ready !== 1'b0 || vec_cnt !== 8'd0 || coverage !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: ready=%b vec=%0d cov=%h done=%b, required 0/0/0000/0",
               vec_ready, vec_cnt, coverage, done);
    end
  endtask

  task automatic test_sweep();
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    checks++;
    if (busy !== 1'b1 || vec_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: busy=%b ready=%b, required 1/1", busy, vec_ready);
    end
    sweep();
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || vec_cnt !== 8'd16 || err_cnt !== 8'd0 ||
        coverage !== 16'hFFFF || first_err_valid !== 1'b0 || vec_ready !== 1'b0) begin
      errors++;
      $display("FAIL sweep_pass: done=%b pass=%b vec=%0d err=%0d cov=%h fev=%b ready=%b, required 1/1/16/0/ffff/0/0",
               done, pass, vec_cnt, err_cnt, coverage, first_err_valid, vec_ready);
    end
    cycle(1'b0, 1'b0, 1'b1, 4'd3, 1'b1);
    checks++;
    if (vec_cnt !== 8'd16 || err_cnt !== 8'd0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL done_hold: vec=%0d err=%0d pass=%b, required 16/0/1", vec_cnt, err_cnt, pass);
    end
  endtask

  task automatic test_lab_fault();
    logic [3:0] vs [6] = '{4'b0000, 4'b0010, 4'b1101, 4'b1011, 4'b0110, 4'b1110};
    bit         ys [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, vs[i], ys[i]);
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if (vec_cnt !== 8'd6 || err_cnt !== 8'd2 || first_err_valid !== 1'b1 ||
        first_err_vec !== 4'b1011 || first_err_y !== 1'b1 || done !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL lab_fault: vec=%0d err=%0d fev=%b fvec=%b fy=%b done=%b pass=%b, required 6/2/1/1011/1/1/0",
               vec_cnt, err_cnt, first_err_valid, first_err_vec, first_err_y, done, pass);
    end
    checks++;
    if (coverage !== cov_word()) begin
      errors++;
      $display("FAIL lab_coverage: got %h required %h", coverage, cov_word());
    end
  endtask

  task automatic test_saturation();
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
    checks++;
    if (vec_cnt !== 8'd255 || err_cnt !== 8'd255 || coverage !== 16'h0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL saturation: vec=%0d err=%0d cov=%h busy=%b, required 255/255/0001/1",
               vec_cnt, err_cnt, coverage, busy);
    end
  endtask

  task automatic test_simultaneous();
    // Still in RUN from the saturation session.
    cycle(1'b1, 1'b0, 1'b1, 4'd5, 1'b1);
    checks++;
    if (vec_cnt !== 8'd0 || err_cnt !== 8'd0 || coverage !== 16'd0 ||
        first_err_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_with_accept: vec=%0d err=%0d cov=%h fev=%b busy=%b, required 0/0/0000/0/1",
               vec_cnt, err_cnt, coverage, first_err_valid, busy);
    end
    cycle(1'b0, 1'b1, 1'b1, 4'd12, golden(12));
    checks++;
    if (vec_cnt !== 8'd1 || done !== 1'b1 || err_cnt !== 8'd0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL stop_with_accept: vec=%0d done=%b err=%0d pass=%b, required 1/1/0/0",
               vec_cnt, done, err_cnt, pass);
    end
    cycle(1'b0, 1'b0, 1'b1, 4'd2, golden(2));
    cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    checks++;
    if (busy !== 1'b1 || vec_cnt !== 8'd0) begin
      errors++;
      $display("FAIL start_with_stop: busy=%b vec=%0d, required 1/0", busy, vec_cnt);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, 4'(i), ~golden(i));
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    checks++;
    if ({vec_ready, busy, done, pass, first_err_valid} !== 5'b0 ||
        vec_cnt !== 8'd0 || err_cnt !== 8'd0 || coverage !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b busy=%b done=%b pass=%b fev=%b vec=%0d err=%0d cov=%h, required all zero",
               vec_ready, busy, done, pass, first_err_valid, vec_cnt, err_cnt, coverage);
    end
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    sweep();
    checks++;
    if (pass !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL reset_then_sweep: pass=%b done=%b, required 1/1", pass, done);
    end
  endtask

  task automatic test_random();
    bit st, sp, v, y;
    logic [3:0] vec;
    for (int n = 0; n < 3000; n++) begin
      st  = ($urandom_range(0, 59) == 0);
      sp  = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 3) != 0);
      vec = 4'($urandom_range(0, 15));
      y   = golden(int'(vec)) ^ ($urandom_range(0, 7) == 0);
      if (m_state != M_RUN && $urandom_range(0, 5) == 0) st = 1'b1;
      cycle(st, sp, v, vec, y);
      checks++;
      if (vec_cnt !== 8'(m_vec) || err_cnt !== 8'(m_err) || coverage !== cov_word() ||
          busy !== (m_state == M_RUN) || vec_ready !== (m_state == M_RUN) ||
          done !== (m_state == M_DONE) || pass !== m_pass() || first_err_valid !== m_fev ||
          (m_fev && (first_err_vec !== 4'(m_fvec) || first_err_y !== m_fy))) begin
        errors++;
        $display("FAIL random[%0d]: vec=%0d/%0d err=%0d/%0d cov=%h/%h busy=%b done=%b pass=%b/%b fev=%b/%b fvec=%h/%h fy=%b/%b (got/required)",
                 n, vec_cnt, m_vec, err_cnt, m_err, coverage, cov_word(), busy, done,
                 pass, m_pass(), first_err_valid, m_fev, first_err_vec, m_fvec[3:0],
                 first_err_y, m_fy);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_sweep();
    test_lab_fault();
    test_saturation();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
